// File: rtl/rom_fetch_sched.sv
// Back-pressurable ROM fetch sequencer: reads nibble pairs, packs them into 8-bit samples
// and broadcasts each sample to two consumers with independent valid/ready handshakes.
`timescale 1ns/1ps
module rom_fetch_sched #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH_NIB = 1024,
  parameter int BASE      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_rom_cen,
  output logic [ADDR_W-1:0] o_rom_a,
  input  logic [3:0]        i_rom_q,
  output logic [7:0]        o_sample,
  output logic              o_l_valid,
  input  logic              i_l_ready,
  output logic              o_h_valid,
  input  logic              i_h_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_sample_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RD_HI, S_RD_LO, S_CAP, S_HOLD, S_DONE} state_t;

  // One extra address bit so the end-of-run address never aliases onto BASE.
  localparam logic [ADDR_W:0]   ADDR_BASE = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]   ADDR_END  = (ADDR_W+1)'(BASE + DEPTH_NIB);
  localparam logic [ADDR_W:0]   ADDR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_MAX   = ADDR_W'(DEPTH_NIB / 2);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_addr;
  logic [3:0]        r_hi;
  logic [7:0]        r_sample;
  logic [1:0]        r_pend;
  logic [1:0]        w_pend_nxt;
  logic              w_deliver;
  logic [ADDR_W-1:0] r_cnt;

  assign o_rom_cen    = !((r_state == S_RD_HI) || (r_state == S_RD_LO));
  assign o_rom_a      = r_addr[ADDR_W-1:0];
  assign o_sample     = r_sample;
  assign o_l_valid    = (r_state == S_HOLD) && r_pend[0];
  assign o_h_valid    = (r_state == S_HOLD) && r_pend[1];
  assign o_busy       = (r_state == S_RD_HI) || (r_state == S_RD_LO) ||
                        (r_state == S_CAP)   || (r_state == S_HOLD);
  assign o_done       = (r_state == S_DONE);
  assign o_sample_cnt = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A sample is delivered on the edge where the last outstanding consumer accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_deliver   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nxt = S_RD_HI;
      S_RD_HI:        w_state_nxt = S_RD_LO;
      S_RD_LO:        w_state_nxt = S_CAP;
      S_CAP: begin
        w_pend_nxt  = 2'b11;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_pend_nxt = r_pend & ~{o_h_valid & i_h_ready, o_l_valid & i_l_ready};
        if (w_pend_nxt == 2'b00) begin
          w_deliver   = 1'b1;
          w_state_nxt = (r_addr == ADDR_END) ? S_DONE : S_RD_HI;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= ADDR_BASE;
      r_hi     <= 4'h0;
      r_sample <= 8'h00;
      r_pend   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_addr <= ADDR_BASE;
            r_cnt  <= '0;
          end
        end
        S_RD_HI: r_addr <= r_addr + ADDR_ONE;
        S_RD_LO: begin
          r_hi   <= i_rom_q;
          r_addr <= r_addr + ADDR_ONE;
        end
        S_CAP:   r_sample <= {r_hi, i_rom_q};
        S_HOLD:  if (w_deliver && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sched.sv
// Self-checking bench for rom_fetch_sched: directed vector table, latency-level reference
// model under randomized readies/ROM contents, mid-run reset, and a small-parameter instance.
`timescale 1ns/1ps
module tb_rom_fetch_sched;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int BASE   = 0;
  localparam int NSAMP  = DEPTH / 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start, lReady, hReady;
  logic              romCen, lValid, hValid, busy, done;
  logic [ADDR_W-1:0] romA, sampleCnt;
  logic [3:0]        romQ = 4'h0;
  logic [7:0]        sample;

  logic              start2;
  logic              romCen2, lValid2, hValid2, busy2, done2;
  logic [ADDR_W-1:0] romA2, sampleCnt2;
  logic [3:0]        romQ2 = 4'h0;
  logic [7:0]        sample2;

  rom_fetch_sched #(.ADDR_W(ADDR_W), .DEPTH_NIB(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .i_start(start), .o_rom_cen(romCen), .o_rom_a(romA),
    .i_rom_q(romQ), .o_sample(sample), .o_l_valid(lValid), .i_l_ready(lReady),
    .o_h_valid(hValid), .i_h_ready(hReady), .o_busy(busy), .o_done(done),
    .o_sample_cnt(sampleCnt));

  rom_fetch_sched #(.ADDR_W(ADDR_W), .DEPTH_NIB(4), .BASE(8)) dut2 (
    .clk(clk), .reset(reset), .i_start(start2), .o_rom_cen(romCen2), .o_rom_a(romA2),
    .i_rom_q(romQ2), .o_sample(sample2), .o_l_valid(lValid2), .i_l_ready(1'b1),
    .o_h_valid(hValid2), .i_h_ready(1'b1), .o_busy(busy2), .o_done(done2),
    .o_sample_cnt(sampleCnt2));

  // Synchronous ROMs: data appears the cycle after the enabled edge.
  logic [3:0] romMem [1024];
  always @(posedge clk) if (!romCen) romQ <= romMem[romA];
  always @(posedge clk) if (!romCen2) romQ2 <= romA2[3:0];

  int nCompared = 0;
  int nMismatch = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch takes 3 edges from start/delivery until the sample is offered.
  bit mRun, mDone, mPendL, mPendH;
  int mK, mTimer;

  task automatic modelReset();
    mRun = 0; mDone = 0; mPendL = 0; mPendH = 0; mK = 0; mTimer = 0;
  endtask

  function automatic logic [7:0] expSample(input int k);
    return {romMem[BASE + 2*k], romMem[BASE + 2*k + 1]};
  endfunction

  task automatic checkOutput();
    bit reading;
    reading = mRun && (mTimer == 3 || mTimer == 2);
    compare("l_valid", 32'(lValid), 32'(mPendL));
    compare("h_valid", 32'(hValid), 32'(mPendH));
    compare("busy", 32'(busy), 32'(mRun));
    compare("done", 32'(done), 32'(mDone));
    compare("sample_cnt", 32'(sampleCnt), 32'(mK));
    compare("rom_cen", 32'(romCen), 32'(!reading));
    if (reading) compare("rom_a", 32'(romA), 32'(BASE + 2*mK + ((mTimer == 3) ? 0 : 1)));
    if (mPendL || mPendH) compare("sample", 32'(sample), 32'(expSample(mK)));
  endtask

  task automatic applyStimulus(input bit st, input bit lr, input bit hr);
    checkOutput();
    start = st; lReady = lr; hReady = hr;
    if (!mRun) begin
      if (st) begin mRun = 1; mDone = 0; mK = 0; mTimer = 3; end
    end else if (mTimer > 0) begin
      mTimer--;
      if (mTimer == 0) begin mPendL = 1; mPendH = 1; end
    end else begin
      if (mPendL && lr) mPendL = 0;
      if (mPendH && hr) mPendH = 0;
      if (!mPendL && !mPendH) begin
        if (mK < NSAMP) mK++;
        if (mK == NSAMP) begin mRun = 0; mDone = 1; end
        else mTimer = 3;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 0; lReady = 0; hReady = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
  endtask

  typedef struct {
    bit st, lr, hr, cen;
    logic [9:0] a;
    bit lv, hv;
    logic [7:0] smp;
    logic [9:0] cnt;
  } vec_t;

  function automatic vec_t mkVec(bit st, bit lr, bit hr, bit cen, logic [9:0] a,
                                 bit lv, bit hv, logic [7:0] smp, logic [9:0] cnt);
    vec_t v;
    v.st = st; v.lr = lr; v.hr = hr; v.cen = cen; v.a = a;
    v.lv = lv; v.hv = hv; v.smp = smp; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [18];
    logic [9:0] addrQ [$];
    logic [7:0] smpQ [$];
    logic [9:0] expAddr [4];
    logic [7:0] expSmp2 [2];

    for (int i = 0; i < 1024; i++) romMem[i] = 4'(i);
    reset = 1'b1; start = 0; lReady = 0; hReady = 0; start2 = 0;
    modelReset();

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    compare("rst_rom_cen", 32'(romCen), 32'(1));
    compare("rst_rom_a", 32'(romA), 32'(BASE));
    compare("rst_sample", 32'(sample), 32'(0));
    compare("rst_valids", 32'({lValid, hValid}), 32'(0));
    compare("rst_busy_done", 32'({busy, done}), 32'(0));
    compare("rst_cnt", 32'(sampleCnt), 32'(0));
    reset = 1'b0;

    // Back-pressure on HPF, stray starts while busy, then simultaneous accept.
    tbl[0]  = mkVec(1, 1, 0, 0, 10'd0, 0, 0, 8'h00, 10'd0);
    tbl[1]  = mkVec(0, 1, 0, 0, 10'd1, 0, 0, 8'h00, 10'd0);
    tbl[2]  = mkVec(0, 1, 0, 1, 10'd0, 0, 0, 8'h00, 10'd0);
    tbl[3]  = mkVec(0, 1, 0, 1, 10'd0, 1, 1, 8'h01, 10'd0);
    for (int i = 4; i < 12; i++) tbl[i] = mkVec(0, 1, 0, 1, 10'd0, 0, 1, 8'h01, 10'd0);
    tbl[12] = mkVec(0, 1, 1, 0, 10'd2, 0, 0, 8'h00, 10'd1);
    tbl[13] = mkVec(1, 0, 0, 0, 10'd3, 0, 0, 8'h00, 10'd1);
    tbl[14] = mkVec(0, 0, 0, 1, 10'd0, 0, 0, 8'h00, 10'd1);
    tbl[15] = mkVec(0, 0, 0, 1, 10'd0, 1, 1, 8'h23, 10'd1);
    tbl[16] = mkVec(1, 0, 0, 1, 10'd0, 1, 1, 8'h23, 10'd1);
    tbl[17] = mkVec(0, 1, 1, 0, 10'd4, 0, 0, 8'h00, 10'd2);
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; lReady = tbl[i].lr; hReady = tbl[i].hr;
      @(posedge clk); #1;
      compare($sformatf("vec%0d_rom_cen", i), 32'(romCen), 32'(tbl[i].cen));
      if (!tbl[i].cen) compare($sformatf("vec%0d_rom_a", i), 32'(romA), 32'(tbl[i].a));
      compare($sformatf("vec%0d_l_valid", i), 32'(lValid), 32'(tbl[i].lv));
      compare($sformatf("vec%0d_h_valid", i), 32'(hValid), 32'(tbl[i].hv));
      compare($sformatf("vec%0d_busy_done", i), 32'({busy, done}), 32'(2'b10));
      compare($sformatf("vec%0d_cnt", i), 32'(sampleCnt), 32'(tbl[i].cnt));
      if (tbl[i].lv || tbl[i].hv) compare($sformatf("vec%0d_sample", i), 32'(sample), 32'(tbl[i].smp));
    end

    // Full run with both readies held high.
    doReset();
    applyStimulus(1, 1, 1);
    for (int c = 0; c < 2200 && !mDone; c++) applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    compare("run1_done", 32'(done), 32'(1));
    compare("run1_busy", 32'(busy), 32'(0));
    compare("run1_cnt", 32'(sampleCnt), 32'(NSAMP));

    // Restart from DONE with random ROM, random readies and ignored starts while busy.
    for (int i = 0; i < 1024; i++) romMem[i] = 4'($urandom);
    applyStimulus(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    for (int c = 0; c < 8000 && !mDone; c++)
      applyStimulus(mRun && ($urandom_range(0, 7) == 0),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    applyStimulus(0, 0, 0);
    compare("run2_done", 32'(done), 32'(1));
    compare("run2_cnt", 32'(sampleCnt), 32'(NSAMP));

    // Asynchronous reset while holding the sixth sample, then a clean restart.
    for (int i = 0; i < 1024; i++) romMem[i] = 4'(i);
    doReset();
    applyStimulus(1, 1, 1);
    for (int c = 0; c < 100 && !(mK == 5 && mPendL && mPendH); c++)
      applyStimulus(0, mK < 5, mK < 5);
    compare("hold5_reached", 32'(mK == 5 && mPendL && mPendH), 32'(1));
    checkOutput();
    #2 reset = 1'b1;
    #1;
    compare("async_rom_cen", 32'(romCen), 32'(1));
    compare("async_valids", 32'({lValid, hValid}), 32'(0));
    compare("async_busy_done", 32'({busy, done}), 32'(0));
    compare("async_cnt", 32'(sampleCnt), 32'(0));
    compare("async_sample", 32'(sample), 32'(0));
    compare("async_rom_a", 32'(romA), 32'(BASE));
    modelReset();
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 10 && !mPendL; c++) applyStimulus(0, 0, 0);
    checkOutput();
    compare("restart_sample", 32'(sample), 32'(8'h01));

    // Small-parameter instance: two samples from address 8.
    expAddr = '{10'd8, 10'd9, 10'd10, 10'd11};
    expSmp2 = '{8'h89, 8'hAB};
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!romCen2) addrQ.push_back(romA2);
      if (lValid2) smpQ.push_back(sample2);
      if (done2) break;
      @(posedge clk); #1;
    end
    compare("p2_addr_count", 32'(addrQ.size()), 32'(4));
    compare("p2_sample_count", 32'(smpQ.size()), 32'(2));
    for (int i = 0; i < 4 && i < addrQ.size(); i++)
      compare($sformatf("p2_rom_a%0d", i), 32'(addrQ[i]), 32'(expAddr[i]));
    for (int i = 0; i < 2 && i < smpQ.size(); i++)
      compare($sformatf("p2_sample%0d", i), 32'(smpQ[i]), 32'(expSmp2[i]));
    compare("p2_done", 32'({done2, busy2}), 32'(2'b10));
    compare("p2_cnt", 32'(sampleCnt2), 32'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
